// File: rtl/v_isa_pkg.sv
// Shared vector ISA definitions: major opcodes, funct3 forms, VALU/VMEM codes,
// the decoded issue bundle and per-SEW replicate/widen helpers.
package v_isa_pkg;

    localparam int unsigned V_DW  = 512;
    localparam int unsigned S_DW  = 64;
    localparam int unsigned OP_DW = 5;
    localparam int unsigned A_DW  = 5;

    localparam logic [6:0] OP_VLOAD  = 7'b0000111;
    localparam logic [6:0] OP_VSTORE = 7'b0100111;
    localparam logic [6:0] OP_VARITH = 7'b1010111;

    localparam logic [2:0] F3_VV = 3'b000;
    localparam logic [2:0] F3_VX = 3'b100;
    localparam logic [2:0] F3_VI = 3'b011;

    localparam logic [6:0] VALU_FUNCT7_MAX = 7'd13;

    // VALU opcode = funct7 + 1, leaving 0 as "no VALU operation".
    typedef enum logic [OP_DW-1:0] {
        VALU_OP_NOP,
        VALU_OP_MUL8TO16,
        VALU_OP_ADD16,
        VALU_OP_DIV16,
        VALU_OP_MAX16,
        VALU_OP_MUL16TO32,
        VALU_OP_ADD32,
        VALU_OP_DIV32,
        VALU_OP_MAX32,
        VALU_OP_MUL32,
        VALU_OP_MIN32,
        VALU_OP_SUB32,
        VALU_OP_RED10MAX32,
        VALU_OP_RED10SUM32,
        VALU_OP_POOL16
    } valu_op_e;

    typedef enum logic [1:0] {
        VMEM_OP_NONE,
        VMEM_OP_LOAD,
        VMEM_OP_STORE
    } vmem_op_e;

    typedef enum logic [1:0] {
        SEW8,
        SEW16,
        SEW32
    } sew_e;

    typedef struct packed {
        logic [OP_DW-1:0] valu_op;
        logic [V_DW-1:0]  v1;
        logic [V_DW-1:0]  v2;
        logic             vmem_ren;
        logic             vmem_wen;
        logic [S_DW-1:0]  vmem_addr;
        logic [V_DW-1:0]  vmem_din;
        logic             wb_en;
        logic             wb_sel;
        logic             wb_double;
        logic [A_DW-1:0]  wb_addr;
        logic             illegal;
    } bundle_t;

    function automatic sew_e arith_sew(input valu_op_e op);
        case (op)
            VALU_OP_MUL8TO16:                      return SEW8;
            VALU_OP_ADD16, VALU_OP_DIV16,
            VALU_OP_MAX16, VALU_OP_MUL16TO32,
            VALU_OP_POOL16:                        return SEW16;
            default:                               return SEW32;
        endcase
    endfunction

    function automatic logic [V_DW-1:0] splat(input sew_e sew, input logic [31:0] x);
        logic [V_DW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < V_DW / 32; i++) begin
            case (sew)
                SEW8:    r[i*32 +: 32] = {4{x[7:0]}};
                SEW16:   r[i*32 +: 32] = {2{x[15:0]}};
                default: r[i*32 +: 32] = x;
            endcase
        end
        return r;
    endfunction

    // Sign-extends the low half of x, element by element, to 2*SEW.
    function automatic logic [V_DW-1:0] widen(input sew_e sew, input logic [V_DW-1:0] x);
        logic [V_DW-1:0] r;
        r = x;
        case (sew)
            SEW8: begin
                for (int unsigned i = 0; i < V_DW / 16; i++)
                    r[i*16 +: 16] = {{8{x[i*8+7]}}, x[i*8 +: 8]};
            end
            SEW16: begin
                for (int unsigned i = 0; i < V_DW / 32; i++)
                    r[i*32 +: 32] = {{16{x[i*16+15]}}, x[i*16 +: 16]};
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/v_scoreboard.sv
// Vector register busy scoreboard: one bit per vreg, set on issue, cleared on
// writeback retirement or flush of the held bundle; set wins over clear.
module v_scoreboard #(
    parameter int unsigned AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic              set_double,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic              clr_double,
    input  logic              flush_en,
    input  logic [AW-1:0]     flush_addr,
    input  logic              flush_double,
    output logic [(1<<AW)-1:0] sb_o
);

    localparam int unsigned N = 1 << AW;

    logic [N-1:0] sb_q;
    logic [N-1:0] sb_d;
    logic [N-1:0] set_m;
    logic [N-1:0] clr_m;
    logic [N-1:0] flush_m;

    // Double masks cover addr and addr+1, wrapping at the top register.
    function automatic logic [N-1:0] mask(input logic [AW-1:0] a, input logic dbl);
        logic [N-1:0]  m;
        logic [AW-1:0] a1;
        a1   = a + 1'b1;
        m    = '0;
        m[a] = 1'b1;
        if (dbl)
            m[a1] = 1'b1;
        return m;
    endfunction

    always_comb begin
        set_m   = set_en   ? mask(set_addr, set_double)     : '0;
        clr_m   = clr_en   ? mask(clr_addr, clr_double)     : '0;
        flush_m = flush_en ? mask(flush_addr, flush_double) : '0;
        sb_d    = (sb_q & ~(clr_m | flush_m)) | set_m;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sb_q <= '0;
        else
            sb_q <= sb_d;
    end

    assign sb_o = sb_q;

endmodule

// File: rtl/v_decode_issue.sv
// Vector decode/issue stage: decodes one instruction per cycle, reads the
// register files, checks the vreg scoreboard and holds the issued bundle.
module v_decode_issue
    import v_isa_pkg::*;
#(
    parameter int unsigned INST_DW   = 32,
    parameter int unsigned REG_DW    = 64,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned VREG_DW   = 512,
    parameter int unsigned VREG_AW   = 5,
    parameter int unsigned VALUOP_DW = 5,
    parameter int unsigned VMEM_AW   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inst_valid_i,
    output logic                 inst_ready_o,
    input  logic [INST_DW-1:0]   inst_i,
    output logic                 rs1_en_o,
    output logic [REG_AW-1:0]    rs1_addr_o,
    input  logic [REG_DW-1:0]    rs1_dout_i,
    output logic                 vs1_en_o,
    output logic [VREG_AW-1:0]   vs1_addr_o,
    input  logic [VREG_DW-1:0]   vs1_dout_i,
    output logic                 vs2_en_o,
    output logic [VREG_AW-1:0]   vs2_addr_o,
    input  logic [VREG_DW-1:0]   vs2_dout_i,
    output logic                 iss_valid_o,
    input  logic                 iss_ready_i,
    output logic [VALUOP_DW-1:0] iss_valu_op_o,
    output logic [VREG_DW-1:0]   iss_v1_o,
    output logic [VREG_DW-1:0]   iss_v2_o,
    output logic                 iss_vmem_ren_o,
    output logic                 iss_vmem_wen_o,
    output logic [VMEM_AW-1:0]   iss_vmem_addr_o,
    output logic [VREG_DW-1:0]   iss_vmem_din_o,
    output logic                 iss_wb_en_o,
    output logic                 iss_wb_sel_o,
    output logic                 iss_wb_double_o,
    output logic [VREG_AW-1:0]   iss_wb_addr_o,
    output logic                 iss_illegal_o,
    input  logic                 wb_done_i,
    input  logic [VREG_AW-1:0]   wb_done_addr_i,
    input  logic                 wb_done_double_i,
    input  logic                 flush_i,
    output logic                 busy_o
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [VREG_AW-1:0]    rs1_f;
    logic [VREG_AW-1:0]    vs2_f;
    logic [VREG_AW-1:0]    vd_f;
    logic [VREG_AW-1:0]    vd_nxt;
    logic [VREG_AW-1:0]    vs2_sel;

    bundle_t               dec;
    vmem_op_e              vmem_op;
    valu_op_e              op;
    sew_e                  sew;
    logic                  wide;
    logic                  legal;
    logic                  use_rs1;
    logic                  use_vs1;
    logic                  use_vs2;
    logic [VREG_DW-1:0]    src1;

    logic                  hz;
    logic                  accept;
    logic                  valid_q;
    logic                  valid_d;
    bundle_t               bundle_q;
    bundle_t               bundle_d;
    logic [(1<<VREG_AW)-1:0] sb_q;

    assign opcode  = inst_i[6:0];
    assign funct3  = inst_i[14:12];
    assign funct7  = inst_i[31:25];
    assign rs1_f   = inst_i[19:15];
    assign vs2_f   = inst_i[24:20];
    assign vd_f    = inst_i[11:7];
    assign vd_nxt  = vd_f + 1'b1;
    assign vs2_sel = (opcode == OP_VSTORE) ? vd_f : vs2_f;

    always_comb begin
        dec     = '0;
        vmem_op = VMEM_OP_NONE;
        op      = VALU_OP_NOP;
        sew     = SEW32;
        wide    = 1'b0;
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_vs1 = 1'b0;
        use_vs2 = 1'b0;
        src1    = '0;
        case (opcode)
            OP_VLOAD: begin
                if (funct3[1:0] == 2'b00) begin
                    legal          = 1'b1;
                    vmem_op        = VMEM_OP_LOAD;
                    use_rs1        = 1'b1;
                    dec.vmem_addr  = rs1_dout_i;
                    dec.wb_en      = 1'b1;
                    dec.wb_sel     = 1'b1;
                    dec.wb_addr    = vd_f;
                end
            end
            OP_VSTORE: begin
                if (funct3 == 3'b000) begin
                    legal          = 1'b1;
                    vmem_op        = VMEM_OP_STORE;
                    use_rs1        = 1'b1;
                    use_vs2        = 1'b1;
                    dec.vmem_addr  = rs1_dout_i;
                    dec.vmem_din   = vs2_dout_i;
                end
            end
            OP_VARITH: begin
                if (funct7 <= VALU_FUNCT7_MAX &&
                    (funct3 == F3_VV || funct3 == F3_VX || funct3 == F3_VI)) begin
                    legal   = 1'b1;
                    op      = valu_op_e'(funct7[4:0] + 5'd1);
                    sew     = arith_sew(op);
                    wide    = (op == VALU_OP_MUL8TO16) || (op == VALU_OP_MUL16TO32);
                    use_vs2 = 1'b1;
                    use_vs1 = (funct3 == F3_VV);
                    use_rs1 = (funct3 == F3_VX);
                    case (funct3)
                        F3_VV:   src1 = vs1_dout_i;
                        F3_VX:   src1 = splat(sew, rs1_dout_i[31:0]);
                        default: src1 = splat(sew, {{27{rs1_f[4]}}, rs1_f});
                    endcase
                    dec.valu_op   = op;
                    dec.v1        = wide ? widen(sew, src1) : src1;
                    dec.v2        = wide ? widen(sew, vs2_dout_i) : vs2_dout_i;
                    dec.wb_en     = 1'b1;
                    dec.wb_double = wide;
                    dec.wb_addr   = vd_f;
                end
            end
            default: ;
        endcase
        dec.vmem_ren = (vmem_op == VMEM_OP_LOAD);
        dec.vmem_wen = (vmem_op == VMEM_OP_STORE);
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    assign rs1_en_o   = inst_valid_i & use_rs1;
    assign rs1_addr_o = rs1_f;
    assign vs1_en_o   = inst_valid_i & use_vs1;
    assign vs1_addr_o = rs1_f;
    assign vs2_en_o   = inst_valid_i & use_vs2;
    assign vs2_addr_o = vs2_sel;

    // Registered scoreboard only: a retirement frees the stall one cycle later.
    assign hz = inst_valid_i &&
                ((use_vs1 && sb_q[rs1_f]) ||
                 (use_vs2 && sb_q[vs2_sel]) ||
                 (dec.wb_en && (sb_q[vd_f] || (dec.wb_double && sb_q[vd_nxt]))));

    assign inst_ready_o = !hz && !flush_i && (!valid_q || iss_ready_i);
    assign accept       = inst_valid_i && inst_ready_o;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
        end else if (iss_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    v_scoreboard #(.AW(VREG_AW)) u_sb (
        .clk          (clk),
        .rst          (rst),
        .set_en       (accept && dec.wb_en),
        .set_addr     (dec.wb_addr),
        .set_double   (dec.wb_double),
        .clr_en       (wb_done_i),
        .clr_addr     (wb_done_addr_i),
        .clr_double   (wb_done_double_i),
        .flush_en     (flush_i && valid_q && bundle_q.wb_en),
        .flush_addr   (bundle_q.wb_addr),
        .flush_double (bundle_q.wb_double),
        .sb_o         (sb_q)
    );

    assign iss_valid_o     = valid_q;
    assign iss_valu_op_o   = bundle_q.valu_op;
    assign iss_v1_o        = bundle_q.v1;
    assign iss_v2_o        = bundle_q.v2;
    assign iss_vmem_ren_o  = bundle_q.vmem_ren;
    assign iss_vmem_wen_o  = bundle_q.vmem_wen;
    assign iss_vmem_addr_o = bundle_q.vmem_addr;
    assign iss_vmem_din_o  = bundle_q.vmem_din;
    assign iss_wb_en_o     = bundle_q.wb_en;
    assign iss_wb_sel_o    = bundle_q.wb_sel;
    assign iss_wb_double_o = bundle_q.wb_double;
    assign iss_wb_addr_o   = bundle_q.wb_addr;
    assign iss_illegal_o   = bundle_q.illegal;
    assign busy_o          = valid_q | (|sb_q);

endmodule

// File: tb/tb_v_decode_issue.sv
// Directed bench for v_decode_issue: decode vector table plus hand-written
// hazard, back-pressure, illegal, flush and reset sequences.
module tb_v_decode_issue;

    localparam logic [6:0] OPL = 7'b0000111;
    localparam logic [6:0] OPS = 7'b0100111;
    localparam logic [6:0] OPA = 7'b1010111;

    logic         clk;
    logic         rst;
    logic         inst_valid_i;
    logic         inst_ready_o;
    logic [31:0]  inst_i;
    logic         rs1_en_o;
    logic [4:0]   rs1_addr_o;
    logic [63:0]  rs1_dout_i;
    logic         vs1_en_o;
    logic [4:0]   vs1_addr_o;
    logic [511:0] vs1_dout_i;
    logic         vs2_en_o;
    logic [4:0]   vs2_addr_o;
    logic [511:0] vs2_dout_i;
    logic         iss_valid_o;
    logic         iss_ready_i;
    logic [4:0]   iss_valu_op_o;
    logic [511:0] iss_v1_o;
    logic [511:0] iss_v2_o;
    logic         iss_vmem_ren_o;
    logic         iss_vmem_wen_o;
    logic [63:0]  iss_vmem_addr_o;
    logic [511:0] iss_vmem_din_o;
    logic         iss_wb_en_o;
    logic         iss_wb_sel_o;
    logic         iss_wb_double_o;
    logic [4:0]   iss_wb_addr_o;
    logic         iss_illegal_o;
    logic         wb_done_i;
    logic [4:0]   wb_done_addr_i;
    logic         wb_done_double_i;
    logic         flush_i;
    logic         busy_o;

    int checks = 0;
    int errors = 0;

    v_decode_issue #(
        .INST_DW(32), .REG_DW(64), .REG_AW(5), .VREG_DW(512),
        .VREG_AW(5), .VALUOP_DW(5), .VMEM_AW(64)
    ) dut (
        .clk(clk), .rst(rst),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o), .inst_i(inst_i),
        .rs1_en_o(rs1_en_o), .rs1_addr_o(rs1_addr_o), .rs1_dout_i(rs1_dout_i),
        .vs1_en_o(vs1_en_o), .vs1_addr_o(vs1_addr_o), .vs1_dout_i(vs1_dout_i),
        .vs2_en_o(vs2_en_o), .vs2_addr_o(vs2_addr_o), .vs2_dout_i(vs2_dout_i),
        .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
        .iss_valu_op_o(iss_valu_op_o), .iss_v1_o(iss_v1_o), .iss_v2_o(iss_v2_o),
        .iss_vmem_ren_o(iss_vmem_ren_o), .iss_vmem_wen_o(iss_vmem_wen_o),
        .iss_vmem_addr_o(iss_vmem_addr_o), .iss_vmem_din_o(iss_vmem_din_o),
        .iss_wb_en_o(iss_wb_en_o), .iss_wb_sel_o(iss_wb_sel_o),
        .iss_wb_double_o(iss_wb_double_o), .iss_wb_addr_o(iss_wb_addr_o),
        .iss_illegal_o(iss_illegal_o),
        .wb_done_i(wb_done_i), .wb_done_addr_i(wb_done_addr_i),
        .wb_done_double_i(wb_done_double_i),
        .flush_i(flush_i), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file contents: vreg k lanes = C3A5_00kk, scalar a = 0123456789ABCD00|a.
    function automatic logic [511:0] vdata(input logic [4:0] k);
        return {16{32'hC3A5_0000 | {27'd0, k}}};
    endfunction
    function automatic logic [63:0] sdata(input logic [4:0] a);
        return 64'h0123_4567_89AB_CD00 | {59'd0, a};
    endfunction

    assign vs1_dout_i = vdata(vs1_addr_o);
    assign vs2_dout_i = vdata(vs2_addr_o);
    assign rs1_dout_i = sdata(rs1_addr_o);

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] vs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] vd, input logic [6:0] opc);
        return {f7, vs2, rs1, f3, vd, opc};
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0]  inst;
        logic         chk_valu;
        logic [4:0]   op;
        logic [511:0] v1;
        logic [511:0] v2;
        logic         ren;
        logic         wen;
        logic         chk_addr;
        logic [63:0]  addr;
        logic         chk_din;
        logic [511:0] din;
        logic         wb_en;
        logic         wb_sel;
        logic         wb_dbl;
        logic [4:0]   wb_addr;
        logic         illegal;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    initial begin
        vecs[0]  = '{enc(7'd5, 5'd2, 5'd1, 3'b000, 5'd3, OPA), 1, 5'd6, vdata(5'd1), vdata(5'd2),
                     0, 0, 0, 64'd0, 0, 512'd0, 1, 0, 0, 5'd3, 0};
        vecs[1]  = '{enc(7'd0, 5'd2, 5'd1, 3'b000, 5'd4, OPA), 1, 5'd1,
                     {8{64'hFFC3FFA5_00000001}}, {8{64'hFFC3FFA5_00000002}},
                     0, 0, 0, 64'd0, 0, 512'd0, 1, 0, 1, 5'd4, 0};
        vecs[2]  = '{enc(7'd5, 5'd2, 5'd31, 3'b011, 5'd6, OPA), 1, 5'd6, {16{32'hFFFFFFFF}}, vdata(5'd2),
                     0, 0, 0, 64'd0, 0, 512'd0, 1, 0, 0, 5'd6, 0};
        vecs[3]  = '{enc(7'd1, 5'd5, 5'd3, 3'b100, 5'd8, OPA), 1, 5'd2, {32{16'hCD03}}, vdata(5'd5),
                     0, 0, 0, 64'd0, 0, 512'd0, 1, 0, 0, 5'd8, 0};
        vecs[4]  = '{enc(7'd0, 5'd0, 5'd5, 3'b000, 5'd9, OPL), 0, 5'd0, 512'd0, 512'd0,
                     1, 0, 1, sdata(5'd5), 0, 512'd0, 1, 1, 0, 5'd9, 0};
        vecs[5]  = '{enc(7'd0, 5'd0, 5'd6, 3'b100, 5'd10, OPL), 0, 5'd0, 512'd0, 512'd0,
                     1, 0, 1, sdata(5'd6), 0, 512'd0, 1, 1, 0, 5'd10, 0};
        vecs[6]  = '{enc(7'd0, 5'd0, 5'd6, 3'b001, 5'd10, OPL), 0, 5'd0, 512'd0, 512'd0,
                     0, 0, 0, 64'd0, 0, 512'd0, 0, 0, 0, 5'd0, 1};
        vecs[7]  = '{enc(7'd0, 5'd0, 5'd7, 3'b000, 5'd11, OPS), 0, 5'd0, 512'd0, 512'd0,
                     0, 1, 1, sdata(5'd7), 1, vdata(5'd11), 0, 0, 0, 5'd0, 0};
        vecs[8]  = '{enc(7'd0, 5'd0, 5'd7, 3'b010, 5'd11, OPS), 0, 5'd0, 512'd0, 512'd0,
                     0, 0, 0, 64'd0, 0, 512'd0, 0, 0, 0, 5'd0, 1};
        vecs[9]  = '{enc(7'd14, 5'd2, 5'd1, 3'b000, 5'd3, OPA), 0, 5'd0, 512'd0, 512'd0,
                     0, 0, 0, 64'd0, 0, 512'd0, 0, 0, 0, 5'd0, 1};
        vecs[10] = '{enc(7'd5, 5'd2, 5'd1, 3'b001, 5'd3, OPA), 0, 5'd0, 512'd0, 512'd0,
                     0, 0, 0, 64'd0, 0, 512'd0, 0, 0, 0, 5'd0, 1};
        vecs[11] = '{enc(7'd5, 5'd2, 5'd1, 3'b000, 5'd3, 7'h7F), 0, 5'd0, 512'd0, 512'd0,
                     0, 0, 0, 64'd0, 0, 512'd0, 0, 0, 0, 5'd0, 1};
        vecs[12] = '{enc(7'd4, 5'd1, 5'd3, 3'b100, 5'd12, OPA), 1, 5'd5,
                     {16{32'hFFFFCD03}}, {8{64'hFFFFC3A5_00000001}},
                     0, 0, 0, 64'd0, 0, 512'd0, 1, 0, 1, 5'd12, 0};
        vecs[13] = '{enc(7'd10, 5'd3, 5'd10, 3'b011, 5'd13, OPA), 1, 5'd11, {16{32'h0000000A}}, vdata(5'd3),
                     0, 0, 0, 64'd0, 0, 512'd0, 1, 0, 0, 5'd13, 0};
        vecs[14] = '{enc(7'd13, 5'd8, 5'd7, 3'b000, 5'd14, OPA), 1, 5'd14, vdata(5'd7), vdata(5'd8),
                     0, 0, 0, 64'd0, 0, 512'd0, 1, 0, 0, 5'd14, 0};

        rst = 1'b0; inst_valid_i = 1'b0; inst_i = '0; iss_ready_i = 1'b1;
        wb_done_i = 1'b0; wb_done_addr_i = '0; wb_done_double_i = 1'b0; flush_i = 1'b0;
        tick; tick;
        chk("rst_iss_valid", iss_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_v1", iss_v1_o, 0);
        chk("rst_wb_en", iss_wb_en_o, 0);
        rst = 1'b1;
        #1 chk("rst_ready", inst_ready_o, 1);
        tick;

        for (int i = 0; i < NV; i++) begin
            inst_i = vecs[i].inst; inst_valid_i = 1'b1;
            #1 chk($sformatf("v%0d_ready", i), inst_ready_o, 1);
            tick;
            inst_valid_i = 1'b0;
            chk($sformatf("v%0d_valid", i), iss_valid_o, 1);
            if (vecs[i].chk_valu) begin
                chk($sformatf("v%0d_op", i), iss_valu_op_o, vecs[i].op);
                chk($sformatf("v%0d_v1", i), iss_v1_o, vecs[i].v1);
                chk($sformatf("v%0d_v2", i), iss_v2_o, vecs[i].v2);
            end
            chk($sformatf("v%0d_ren", i), iss_vmem_ren_o, vecs[i].ren);
            chk($sformatf("v%0d_wen", i), iss_vmem_wen_o, vecs[i].wen);
            if (vecs[i].chk_addr) chk($sformatf("v%0d_addr", i), iss_vmem_addr_o, vecs[i].addr);
            if (vecs[i].chk_din)  chk($sformatf("v%0d_din", i), iss_vmem_din_o, vecs[i].din);
            chk($sformatf("v%0d_wb_en", i), iss_wb_en_o, vecs[i].wb_en);
            chk($sformatf("v%0d_wb_sel", i), iss_wb_sel_o, vecs[i].wb_sel);
            chk($sformatf("v%0d_wb_dbl", i), iss_wb_double_o, vecs[i].wb_dbl);
            if (vecs[i].wb_en) chk($sformatf("v%0d_wb_addr", i), iss_wb_addr_o, vecs[i].wb_addr);
            chk($sformatf("v%0d_illegal", i), iss_illegal_o, vecs[i].illegal);
            wb_done_i = vecs[i].wb_en; wb_done_addr_i = vecs[i].wb_addr; wb_done_double_i = vecs[i].wb_dbl;
            tick;
            wb_done_i = 1'b0;
            chk($sformatf("v%0d_drain_valid", i), iss_valid_o, 0);
            chk($sformatf("v%0d_drain_busy", i), busy_o, 0);
        end

        // RAW/WAW on a widened destination, released only after retirement.
        inst_i = enc(7'd0, 5'd2, 5'd1, 3'b000, 5'd4, OPA); inst_valid_i = 1'b1;
        tick;
        inst_i = enc(7'd1, 5'd4, 5'd1, 3'b000, 5'd5, OPA);
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("hz_stall%0d", c), inst_ready_o, 0);
            tick;
        end
        chk("hz_busy", busy_o, 1);
        wb_done_i = 1'b1; wb_done_addr_i = 5'd4; wb_done_double_i = 1'b1;
        #1 chk("hz_no_bypass", inst_ready_o, 0);
        tick;
        wb_done_i = 1'b0;
        #1 chk("hz_release", inst_ready_o, 1);
        tick;
        inst_valid_i = 1'b0;
        chk("hz_iss_valid", iss_valid_o, 1);
        chk("hz_iss_op", iss_valu_op_o, 2);
        chk("hz_iss_vd", iss_wb_addr_o, 5);
        inst_i = enc(7'd5, 5'd5, 5'd1, 3'b000, 5'd20, OPA); inst_valid_i = 1'b1;
        #1 chk("hz_sb5_set", inst_ready_o, 0);
        inst_i = enc(7'd5, 5'd4, 5'd4, 3'b000, 5'd20, OPA);
        #1 chk("hz_sb4_clear", inst_ready_o, 1);
        inst_valid_i = 1'b0;
        wb_done_i = 1'b1; wb_done_addr_i = 5'd5; wb_done_double_i = 1'b0;
        tick;
        wb_done_i = 1'b0;
        chk("hz_end_busy", busy_o, 0);

        // Downstream back-pressure with a second instruction pending.
        inst_i = enc(7'd5, 5'd2, 5'd1, 3'b000, 5'd3, OPA); inst_valid_i = 1'b1;
        tick;
        iss_ready_i = 1'b0;
        inst_i = enc(7'd5, 5'd2, 5'd31, 3'b011, 5'd6, OPA);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_valid%0d", c), iss_valid_o, 1);
            chk($sformatf("bp_vd%0d", c), iss_wb_addr_o, 3);
            chk($sformatf("bp_v1_%0d", c), iss_v1_o, vdata(5'd1));
            #1 chk($sformatf("bp_ready%0d", c), inst_ready_o, 0);
            tick;
        end
        iss_ready_i = 1'b1;
        #1 chk("bp_b2b_ready", inst_ready_o, 1);
        tick;
        inst_valid_i = 1'b0;
        chk("bp_b2b_valid", iss_valid_o, 1);
        chk("bp_b2b_vd", iss_wb_addr_o, 6);
        chk("bp_b2b_v1", iss_v1_o, {16{32'hFFFFFFFF}});
        wb_done_i = 1'b1; wb_done_addr_i = 5'd3; wb_done_double_i = 1'b0;
        tick;
        wb_done_addr_i = 5'd6;
        tick;
        wb_done_i = 1'b0;
        chk("bp_end_busy", busy_o, 0);

        // Illegal encoding leaves the scoreboard untouched.
        inst_i = enc(7'd5, 5'd2, 5'd1, 3'b000, 5'd3, OPA); inst_valid_i = 1'b1;
        tick;
        inst_i = enc(7'd5, 5'd2, 5'd1, 3'b000, 5'd3, 7'h7F);
        #1 chk("ill_ready", inst_ready_o, 1);
        tick;
        inst_valid_i = 1'b0;
        chk("ill_flag", iss_illegal_o, 1);
        chk("ill_valid", iss_valid_o, 1);
        chk("ill_enables", {iss_wb_en_o, iss_vmem_ren_o, iss_vmem_wen_o, iss_wb_double_o}, 0);
        inst_i = enc(7'd5, 5'd3, 5'd1, 3'b000, 5'd9, OPA); inst_valid_i = 1'b1;
        #1 chk("ill_sb3_kept", inst_ready_o, 0);
        inst_valid_i = 1'b0;
        wb_done_i = 1'b1; wb_done_addr_i = 5'd3; wb_done_double_i = 1'b0;
        tick;
        wb_done_i = 1'b0;
        tick;
        chk("ill_end_busy", busy_o, 0);

        // Flush of a held VMAX32 to v7.
        inst_i = enc(7'd7, 5'd2, 5'd1, 3'b000, 5'd7, OPA); inst_valid_i = 1'b1;
        tick;
        iss_ready_i = 1'b0;
        chk("fl_held_valid", iss_valid_o, 1);
        chk("fl_held_op", iss_valu_op_o, 8);
        inst_i = enc(7'd5, 5'd1, 5'd2, 3'b000, 5'd9, OPA); flush_i = 1'b1;
        #1 chk("fl_no_accept", inst_ready_o, 0);
        tick;
        flush_i = 1'b0; inst_valid_i = 1'b0;
        chk("fl_valid", iss_valid_o, 0);
        chk("fl_busy", busy_o, 0);
        inst_i = enc(7'd5, 5'd7, 5'd7, 3'b000, 5'd9, OPA); inst_valid_i = 1'b1;
        #1 chk("fl_sb7_clear", inst_ready_o, 1);
        inst_valid_i = 1'b0; iss_ready_i = 1'b1;
        tick;

        // Asynchronous reset during a stall.
        iss_ready_i = 1'b0;
        inst_i = enc(7'd5, 5'd2, 5'd1, 3'b000, 5'd3, OPA); inst_valid_i = 1'b1;
        tick;
        inst_i = enc(7'd5, 5'd3, 5'd1, 3'b000, 5'd9, OPA);
        #1 chk("ar_stall", inst_ready_o, 0);
        #1 rst = 1'b0;
        #1;
        chk("ar_valid", iss_valid_o, 0);
        chk("ar_op", iss_valu_op_o, 0);
        chk("ar_wb_en", iss_wb_en_o, 0);
        chk("ar_v1", iss_v1_o, 0);
        chk("ar_busy", busy_o, 0);
        inst_valid_i = 1'b0; iss_ready_i = 1'b1;
        tick;
        rst = 1'b1;
        inst_valid_i = 1'b1;
        #1 chk("ar_ready_after", inst_ready_o, 1);
        inst_valid_i = 1'b0;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
